// File: rtl/dec2_rr_arbiter.sv
// Round-robin arbiter driving a shared 2-to-4 decoder (A, B, active-low D).
// Optional grant timeout: define DEC2_ARB_TIMEOUT_EN to cap grants at HOLD_MAX cycles.
module dec2_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic       dec_d,
    output logic       dec_a,
    output logic       dec_b,
    output logic [3:0] grant,
    output logic       busy,
    output logic       timeout
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("HOLD_MAX out of range");
    end

    logic [0:0] state;
    logic [1:0] owner;
    logic [1:0] last;
    logic [1:0] win;
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] c3;
    logic       to_hit;

    assign c1 = last + 2'd1;
    assign c2 = last + 2'd2;
    assign c3 = last + 2'd3;

    // Scan starts just after the previous winner; last itself is lowest priority.
    always_comb begin
        win = last;
        if (req[c1])
            win = c1;
        else if (req[c2])
            win = c2;
        else if (req[c3])
            win = c3;
    end

`ifdef DEC2_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_cnt;
    logic       timeout_q;

    assign to_hit  = (hold_cnt == HOLD_LAST);
    assign timeout = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (state == S_IDLE) begin
                hold_cnt <= 8'd0;
            end else if (req[owner] && to_hit) begin
                timeout_q <= 1'b1;
            end else if (req[owner] && hold_cnt != 8'hFF) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            owner <= 2'd0;
            last  <= 2'd3;
            dec_d <= 1'b1;
            dec_a <= 1'b0;
            dec_b <= 1'b0;
            grant <= 4'b0000;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (|req) begin
                        state <= S_GRANT;
                        owner <= win;
                        last  <= win;
                        dec_a <= win[1];
                        dec_b <= win[0];
                        dec_d <= 1'b0;
                        grant <= 4'b0001 << win;
                        busy  <= 1'b1;
                    end
                end
                S_GRANT: begin
                    // dec_a/dec_b keep the old select while D is inactive.
                    if (!req[owner] || to_hit) begin
                        state <= S_IDLE;
                        dec_d <= 1'b1;
                        grant <= 4'b0000;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec2_rr_arbiter.sv
// Randomized + directed bench for dec2_rr_arbiter against a behavioural model.
// Honours DEC2_ARB_TIMEOUT_EN the same way the design does.
module tb_dec2_rr_arbiter;

    localparam int HM = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       dec_d;
    logic       dec_a;
    logic       dec_b;
    logic [3:0] grant;
    logic       busy;
    logic       timeout;

    int n_chk = 0;
    int n_fail = 0;

    int m_busy = 0;
    int m_owner = 0;
    int m_last = 3;
    int m_cnt = 0;
    int m_sel = 0;
    int m_to = 0;

    dec2_rr_arbiter #(.HOLD_MAX(HM)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .dec_d(dec_d),
        .dec_a(dec_a),
        .dec_b(dec_b),
        .grant(grant),
        .busy(busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference behaviour: one arbitration decision per rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0;
            m_owner = 0;
            m_last = 3;
            m_cnt = 0;
            m_sel = 0;
            m_to = 0;
        end else begin
            m_to = 0;
            if (m_busy == 0) begin
                for (int k = 1; k <= 4; k++) begin
                    int idx;
                    idx = (m_last + k) % 4;
                    if (m_busy == 0 && req[idx]) begin
                        m_busy = 1;
                        m_owner = idx;
                        m_last = idx;
                        m_sel = idx;
                        m_cnt = 1;
                    end
                end
            end else if (!req[m_owner]) begin
                m_busy = 0;
            end else begin
`ifdef DEC2_ARB_TIMEOUT_EN
                if (m_cnt >= HM) begin
                    m_busy = 0;
                    m_to = 1;
                end else begin
                    m_cnt++;
                end
`else
                m_cnt++;
`endif
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] eg;
        logic [3:0] yd;
        eg = (m_busy != 0) ? 4'(1 << m_owner) : 4'b0000;
        yd = dec_d ? 4'b0000 : 4'(1 << {dec_a, dec_b});
        chk("grant", 32'(grant), 32'(eg));
        chk("dec_d", 32'(dec_d), 32'(m_busy == 0));
        chk("dec_a", 32'(dec_a), 32'(m_sel / 2));
        chk("dec_b", 32'(dec_b), 32'(m_sel % 2));
        chk("busy", 32'(busy), 32'(m_busy != 0));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("decoder", 32'(grant), 32'(yd));
    end

    task automatic step(input logic [3:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_dec_d", 32'(dec_d), 32'h1);
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] r;
        repeat (2) @(negedge clk);
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_dec_d", 32'(dec_d), 32'h1);
        chk("reset_sel", 32'({dec_a, dec_b}), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;

        step(4'b0001);
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_dec_d", 32'(dec_d), 32'h0);
        chk("t1_sel", 32'({dec_a, dec_b}), 32'h0);
        step(4'b0000);
        chk("t1_rel_grant", 32'(grant), 32'h0);
        chk("t1_rel_dec_d", 32'(dec_d), 32'h1);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            logic [3:0] bit_o;
            bit_o = 4'(1 << (i % 4));
            step(4'b1111);
            chk("rr_grant", 32'(grant), 32'(bit_o));
            step(4'b1111);
            step(4'b1111);
            step(4'b1111 & ~bit_o);
            chk("rr_idle", 32'(grant), 32'h0);
        end

        do_reset();
        step(4'b0100);
        chk("o2_grant", 32'(grant), 32'h4);
        step(4'b0110);
        step(4'b0110);
        step(4'b0010);
        chk("o2_rel", 32'(grant), 32'h0);
        step(4'b0010);
        chk("o1_grant", 32'(grant), 32'h2);
        chk("o1_sel", 32'({dec_a, dec_b}), 32'h1);
        step(4'b0000);

        do_reset();
        step(4'b1000);
        chk("o3_grant", 32'(grant), 32'h8);
        chk("o3_sel", 32'({dec_a, dec_b}), 32'h3);
        do_reset();
        step(4'b1001);
        chk("post_rst_grant", 32'(grant), 32'h1);
        step(4'b0000);

`ifdef DEC2_ARB_TIMEOUT_EN
        do_reset();
        for (int i = 0; i < HM; i++) begin
            step(4'b0011);
            chk("to_hold0", 32'(grant), 32'h1);
        end
        step(4'b0011);
        chk("to_pulse", 32'(timeout), 32'h1);
        chk("to_idle", 32'(grant), 32'h0);
        step(4'b0011);
        chk("to_next", 32'(grant), 32'h2);
        chk("to_clear", 32'(timeout), 32'h0);
        step(4'b0000);
`endif

        for (int c = 0; c < 1500; c++) begin
            r = 4'($urandom_range(0, 15));
            if (m_busy != 0 && $urandom_range(0, 4) != 0)
                r[m_owner] = 1'b1;
            if ($urandom_range(0, 199) == 0)
                do_reset();
            else
                step(r);
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
